// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving an external shared add/sub unit.
// Define MDU_EARLY_OUT_EN to skip the iteration phase for zero operands / zero divisor.
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_flag,
    input  logic [WIDTH-1:0] add_sum
);

    localparam int CW = $clog2(ITERS);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             is_signed, is_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] sh_rem;
    logic             msb_out, borrow, carry;
    logic [WIDTH:0]   mul_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Restoring-divide view: {rem, dvd} shifted left by one before the trial subtract.
    assign sh_rem  = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
    assign msb_out = acc_hi_q[WIDTH-1];
    assign borrow  = (~sh_rem[WIDTH-1] & opnd_q[WIDTH-1])
                   | (~(sh_rem[WIDTH-1] ^ opnd_q[WIDTH-1]) & add_sum[WIDTH-1]);
    assign carry   = (acc_hi_q[WIDTH-1] & opnd_q[WIDTH-1])
                   | ((acc_hi_q[WIDTH-1] | opnd_q[WIDTH-1]) & ~add_sum[WIDTH-1]);
    assign mul_next = acc_lo_q[0] ? {carry, add_sum} : {1'b0, acc_hi_q};

    assign hi = hi_q;
    assign lo = lo_q;

    // Adder operands depend on registered state only, so add_sum never loops back here.
    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_flag = 1'b1;
        if (state_q == S_ITER) begin
            add_b = opnd_q;
            if (is_div) begin
                add_a    = sh_rem;
                add_flag = 1'b0;
            end else begin
                add_a = acc_hi_q;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy     = 1'b0;
        done     = 1'b0;
        prod     = {acc_hi_q, acc_lo_q};
        quo      = acc_lo_q;
        rem      = acc_hi_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = src_a;
                    b_d     = src_b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                busy     = 1'b1;
                acc_hi_d = '0;
                acc_lo_d = is_div ? mag_a : mag_b;
                opnd_d   = is_div ? mag_b : mag_a;
                sign_q_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                sign_r_d = is_signed & a_q[WIDTH-1];
                cnt_d    = CW'(ITERS - 1);
                state_d  = S_ITER;
`ifdef MDU_EARLY_OUT_EN
                if ((!is_div && (a_q == '0 || b_q == '0)) || (is_div && b_q == '0)) begin
                    acc_lo_d = '0;
                    state_d  = S_FIX;
                end
`endif
            end
            S_ITER: begin
                busy  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
                if (is_div) begin
                    if (msb_out | ~borrow) begin
                        acc_hi_d = add_sum;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = sh_rem;
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_next[WIDTH:1];
                    acc_lo_d = {mul_next[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                busy = 1'b1;
                if (is_div) begin
                    if (op_q == OP_DIV && sign_q_q) quo = -acc_lo_q;
                    if (op_q == OP_DIV && sign_r_q) rem = -acc_hi_q;
                    if (b_q == '0) begin
                        quo = '1;
                        rem = a_q;
                    end
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    if (op_q == OP_MULT && sign_q_q) prod = -{acc_hi_q, acc_lo_q};
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed + random bench for mdu_sequencer; the external add/sub unit is modelled here.
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done;
    logic [W-1:0] hi, lo;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_flag;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  last_res;

    always #5 clk = ~clk;

    assign add_sum = add_flag ? add_a + add_b : add_a - add_b;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_flag (add_flag),
        .add_sum  (add_sum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results from native arithmetic; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        if ((!o[1] && (a == 32'h0 || b == 32'h0)) || (o[1] && b == 32'h0)) return 3;
`endif
        return 35;
    endfunction

    // Runs one op from start; extra_cyc injects a second start, rst_cyc asserts reset.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int extra_cyc, input int rst_cyc);
        int lat, done_cnt, done_at;
        logic busy_ok, flag_ok, hold_ok, after_rst, exp_busy;
        logic [63:0] exp_res, want;
        lat     = model_lat(o, a, b);
        exp_res = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        exp_q.push_back(exp_res);
        @(posedge clk);
        busy_ok = 1'b1; flag_ok = 1'b1; hold_ok = 1'b1;
        done_cnt = 0; done_at = 0;
        for (int k = 1; k <= lat + 5; k++) begin
            @(negedge clk);
            after_rst = (rst_cyc != 0) && (k > rst_cyc);
            if (rst_cyc != 0 && k == rst_cyc + 1) begin
                check("rst_busy", 64'(busy), 64'h0);
                check("rst_done", 64'(done), 64'h0);
                check("rst_hilo", {hi, lo}, 64'h0);
                check("rst_flag", 64'(add_flag), 64'h1);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) done_at = k;
                if (exp_q.size() > 0) begin
                    want = exp_q.pop_front();
                    check("result", {hi, lo}, want);
                end else begin
                    check("unexpected_done", 64'(done_cnt), 64'h0);
                end
            end
            exp_busy = (k < lat) && !after_rst;
            if (busy !== exp_busy) busy_ok = 1'b0;
            if (after_rst) begin
                if ({hi, lo} !== 64'h0) hold_ok = 1'b0;
            end else if (k < lat) begin
                if ({hi, lo} !== last_res) hold_ok = 1'b0;
            end
            if (!after_rst && k >= 2 && k <= lat - 2) begin
                if (add_flag !== ~o[1]) flag_ok = 1'b0;
            end
            if (!after_rst && (k == 1 || k == lat - 1)) begin
                if (add_flag !== 1'b1 || add_a !== '0 || add_b !== '0) flag_ok = 1'b0;
            end
            start = (k == extra_cyc);
            if (k == extra_cyc) begin
                op = ~o; src_a = $urandom; src_b = $urandom;
            end
            rst = (rst_cyc != 0) && (k == rst_cyc);
        end
        start = 1'b0;
        rst   = 1'b0;
        check("busy_window", 64'(busy_ok), 64'h1);
        check("adder_ctrl", 64'(flag_ok), 64'h1);
        check("hilo_hold", 64'(hold_ok), 64'h1);
        if (rst_cyc == 0) begin
            check("done_count", 64'(done_cnt), 64'h1);
            check("done_cycle", 64'(done_at), 64'(lat));
            last_res = exp_res;
        end else begin
            check("no_done_after_rst", 64'(done_cnt), 64'h0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            last_res = 64'h0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        last_res = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_hi", 64'(hi), 64'h0);
        check("reset_lo", 64'(lo), 64'h0);
        check("reset_add_a", 64'(add_a), 64'h0);
        check("reset_add_b", 64'(add_b), 64'h0);
        check("reset_add_flag", 64'(add_flag), 64'h1);
        rst = 1'b0;

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max", last_res, 64'hFFFF_FFFE_0000_0001);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(2'b11, 32'd100, 32'd7, 0, 0);
        do_op(2'b11, 32'h1234_5678, 32'h0, 0, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(2'b10, 32'hFFFF_FFFB, 32'h0, 0, 0);
        do_op(2'b00, 32'h0, 32'h1234_5678, 0, 0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
        do_op(2'b10, 32'd17, 32'hFFFF_FFFB, 0, 0);
        for (int i = 0; i < 6; i++) begin
            do_op(2'($urandom_range(0, 3)), $urandom, $urandom, 0, 0);
        end
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 10, 0);
        do_op(2'b01, 32'h0001_0003, 32'h0000_0101, 0, 20);
        do_op(2'b11, 32'd1000, 32'd33, 0, 0);
        check("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
